// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with accumulator and {N,Z,C,V} flag register.
//   clk, rst_n                  : clock (rising edge), async active-low reset
//   ALU_IN_VALID / ALU_IN_READY : request handshake; READY is high only in IDLE
//   ALU_DA, ALU_DB, ALU_USE_ACC : operands; USE_ACC selects the accumulator as A
//   ALU_CTL, ALU_SHIFT, ACC_CTL : opcode, shift amount, accumulator control
//   ALU_OUT_VALID / ALU_OUT_READY : result handshake; VALID is high only in DONE
//   ALU_DC, ALU_FLAGS, ALU_ACC  : registered result, flags and accumulator
module alu_seq #(
    parameter  int unsigned WIDTH   = 16,
    localparam int unsigned SHIFT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ALU_IN_VALID,
    output logic               ALU_IN_READY,
    input  logic [WIDTH-1:0]   ALU_DA,
    input  logic [WIDTH-1:0]   ALU_DB,
    input  logic               ALU_USE_ACC,
    input  logic [3:0]         ALU_CTL,
    input  logic [SHIFT_W-1:0] ALU_SHIFT,
    input  logic [1:0]         ACC_CTL,
    output logic               ALU_OUT_VALID,
    input  logic               ALU_OUT_READY,
    output logic [WIDTH-1:0]   ALU_DC,
    output logic [3:0]         ALU_FLAGS,
    output logic [WIDTH-1:0]   ALU_ACC
);

    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    localparam logic [1:0] ACC_HOLD  = 2'b00;
    localparam logic [1:0] ACC_LOAD  = 2'b01;
    localparam logic [1:0] ACC_CLEAR = 2'b10;
    localparam logic [1:0] ACC_COMPL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   dc_q, dc_d;
    logic [3:0]         flags_q, flags_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic [SHIFT_W-1:0] cnt_q, cnt_d;
    logic               acc_wr_q, acc_wr_d;

    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   res;
    logic               res_c;
    logic               res_v;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     sh_w;
    logic [PW-1:0]      prod_sum;

    assign ALU_IN_READY  = (state_q == S_IDLE);
    assign ALU_OUT_VALID = (state_q == S_DONE);
    assign ALU_DC        = dc_q;
    assign ALU_FLAGS     = flags_q;
    assign ALU_ACC       = acc_q;

    assign op_a = ALU_USE_ACC ? acc_q : ALU_DA;

    // Single-cycle result path, evaluated on the accept edge.
    // Shifts use a one-bit guard position so the last bit shifted out lands in it
    // (and is naturally 0 for a zero shift).
    always_comb begin
        res   = op_a;
        res_c = 1'b0;
        res_v = 1'b0;
        sum_w = '0;
        sh_w  = '0;
        if (ACC_CTL == ACC_CLEAR) begin
            res = '0;
        end else if (ACC_CTL == ACC_COMPL) begin
            res = ~acc_q;
        end else begin
            unique case (ALU_CTL)
                OP_ADD: begin
                    sum_w = {1'b0, op_a} + {1'b0, ALU_DB};
                    res   = sum_w[WIDTH-1:0];
                    res_c = sum_w[WIDTH];
                    res_v = (op_a[WIDTH-1] == ALU_DB[WIDTH-1]) &&
                            (res[WIDTH-1] != op_a[WIDTH-1]);
                end
                OP_SUB: begin
                    sum_w = {1'b0, op_a} + {1'b0, ~ALU_DB} + (WIDTH+1)'(1);
                    res   = sum_w[WIDTH-1:0];
                    res_c = sum_w[WIDTH];
                    res_v = (op_a[WIDTH-1] != ALU_DB[WIDTH-1]) &&
                            (res[WIDTH-1] != op_a[WIDTH-1]);
                end
                OP_AND: res = op_a & ALU_DB;
                OP_OR:  res = op_a | ALU_DB;
                OP_XOR: res = op_a ^ ALU_DB;
                OP_SLL: begin
                    sh_w  = {1'b0, op_a} << ALU_SHIFT;
                    res   = sh_w[WIDTH-1:0];
                    res_c = sh_w[WIDTH];
                end
                OP_SRL: begin
                    sh_w  = {op_a, 1'b0} >> ALU_SHIFT;
                    res   = sh_w[WIDTH:1];
                    res_c = sh_w[0];
                end
                OP_SRA: begin
                    sh_w  = $signed({op_a, 1'b0}) >>> ALU_SHIFT;
                    res   = sh_w[WIDTH:1];
                    res_c = sh_w[0];
                end
                default: res = op_a;
            endcase
        end
    end

    // One shift-add partial product per MUL cycle.
    assign prod_sum = prod_q + (mplier_q[0] ? mcand_q : '0);

    // Next-state and register-update logic.
    always_comb begin
        state_d  = state_q;
        dc_d     = dc_q;
        flags_d  = flags_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        acc_wr_d = acc_wr_q;
        unique case (state_q)
            S_IDLE: begin
                if (ALU_IN_VALID) begin
                    if (!ACC_CTL[1] && (ALU_CTL == OP_MUL)) begin
                        state_d  = S_MUL;
                        mcand_d  = PW'(op_a);
                        mplier_d = ALU_DB;
                        prod_d   = '0;
                        cnt_d    = '0;
                        acc_wr_d = (ACC_CTL == ACC_LOAD);
                    end else begin
                        state_d = S_DONE;
                        dc_d    = res;
                        flags_d = {res[WIDTH-1], (res == '0), res_c, res_v};
                        if (ACC_CTL != ACC_HOLD) begin
                            acc_d = res;
                        end
                    end
                end
            end
            S_MUL: begin
                prod_d   = prod_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHIFT_W'(1);
                if (cnt_q == SHIFT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    dc_d    = prod_sum[WIDTH-1:0];
                    flags_d = {prod_sum[WIDTH-1], (prod_sum[WIDTH-1:0] == '0),
                               (prod_sum[PW-1:WIDTH] != '0),
                               (prod_sum[PW-1:WIDTH] != '0)};
                    if (acc_wr_q) begin
                        acc_d = prod_sum[WIDTH-1:0];
                    end
                end
            end
            S_DONE: begin
                if (ALU_OUT_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dc_q     <= '0;
            flags_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            acc_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dc_q     <= dc_d;
            flags_q  <= flags_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            acc_wr_q <= acc_wr_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed plus randomized checks of alu_seq (WIDTH=16) against an
// arithmetic reference model.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        ALU_IN_VALID;
    logic        ALU_IN_READY;
    logic [15:0] ALU_DA;
    logic [15:0] ALU_DB;
    logic        ALU_USE_ACC;
    logic [3:0]  ALU_CTL;
    logic [3:0]  ALU_SHIFT;
    logic [1:0]  ACC_CTL;
    logic        ALU_OUT_VALID;
    logic        ALU_OUT_READY;
    logic [15:0] ALU_DC;
    logic [3:0]  ALU_FLAGS;
    logic [15:0] ALU_ACC;

    int checks = 0;
    int errors = 0;
    logic [15:0] model_acc = 16'h0;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ALU_IN_VALID(ALU_IN_VALID), .ALU_IN_READY(ALU_IN_READY),
        .ALU_DA(ALU_DA), .ALU_DB(ALU_DB), .ALU_USE_ACC(ALU_USE_ACC),
        .ALU_CTL(ALU_CTL), .ALU_SHIFT(ALU_SHIFT), .ACC_CTL(ACC_CTL),
        .ALU_OUT_VALID(ALU_OUT_VALID), .ALU_OUT_READY(ALU_OUT_READY),
        .ALU_DC(ALU_DC), .ALU_FLAGS(ALU_FLAGS), .ALU_ACC(ALU_ACC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation definitions.
    task automatic model(input logic [3:0] ctl, input logic [1:0] actl,
                         input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                         input logic [15:0] acc,
                         output logic [15:0] r, output logic [3:0] f,
                         output logic [15:0] acc_n, output int lat);
        int u, ss, si;
        longint p;
        logic c, v;
        c = 1'b0; v = 1'b0; lat = 1; si = int'(s);
        if (actl == 2'b10) r = 16'h0;
        else if (actl == 2'b11) r = ~acc;
        else begin
            case (ctl)
                4'd0: begin
                    u = int'(a) + int'(b); r = u[15:0]; c = u[16];
                    ss = int'($signed(a)) + int'($signed(b));
                    v = (ss > 32767) || (ss < -32768);
                end
                4'd1: begin
                    u = int'(a) - int'(b); r = u[15:0]; c = (a >= b);
                    ss = int'($signed(a)) - int'($signed(b));
                    v = (ss > 32767) || (ss < -32768);
                end
                4'd2: r = a & b;
                4'd3: r = a | b;
                4'd7: r = a ^ b;
                4'd4: begin
                    u = int'(a) << si; r = u[15:0];
                    c = (si != 0) ? a[16-si] : 1'b0;
                end
                4'd5: begin
                    u = int'(a) >> si; r = u[15:0];
                    c = (si != 0) ? a[si-1] : 1'b0;
                end
                4'd6: begin
                    ss = int'($signed(a)) >>> si; r = ss[15:0];
                    c = (si != 0) ? a[si-1] : 1'b0;
                end
                4'd8: begin
                    p = longint'(a) * longint'(b); r = p[15:0];
                    c = (p >> 16) != 0; v = c; lat = 17;
                end
                default: r = a;
            endcase
        end
        f = {r[15], (r == 16'h0), c, v};
        acc_n = (actl != 2'b00) ? r : acc;
    endtask

    // Issue one op, check latency/result, hold the result for 'hold' cycles
    // while pulsing IN_VALID (which must be dropped), then release.
    task automatic do_op(input logic [3:0] ctl, input logic [15:0] da, input logic [15:0] db,
                         input logic ua, input logic [3:0] s, input logic [1:0] actl,
                         input int hold);
        logic [15:0] a, r, accn;
        logic [3:0] f;
        int lat, cyc;
        a = ua ? model_acc : da;
        model(ctl, actl, a, db, s, model_acc, r, f, accn, lat);
        @(negedge clk);
        check("in_ready_idle", ALU_IN_READY, 1'b1);
        ALU_CTL = ctl; ALU_DA = da; ALU_DB = db; ALU_USE_ACC = ua;
        ALU_SHIFT = s; ACC_CTL = actl; ALU_IN_VALID = 1'b1;
        @(posedge clk); #1;
        ALU_IN_VALID = 1'b0;
        ALU_DA = $urandom; ALU_DB = $urandom;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!ALU_OUT_VALID) check("in_ready_busy", ALU_IN_READY, 1'b0);
        end while (!ALU_OUT_VALID && cyc < 40);
        check("latency", cyc, lat);
        check("dc", ALU_DC, r);
        check("flags", ALU_FLAGS, f);
        check("acc", ALU_ACC, accn);
        model_acc = accn;
        for (int k = 0; k < hold; k++) begin
            ALU_IN_VALID = 1'b1; ACC_CTL = 2'b10; ALU_CTL = 4'd0;
            @(negedge clk);
            check("hold_valid", ALU_OUT_VALID, 1'b1);
            check("hold_in_ready", ALU_IN_READY, 1'b0);
            check("hold_dc", ALU_DC, r);
            check("hold_flags", ALU_FLAGS, f);
        end
        ALU_IN_VALID = 1'b0;
        ALU_OUT_READY = 1'b1;
        @(posedge clk); #1;
        ALU_OUT_READY = 1'b0;
        @(negedge clk);
        check("release_idle", ALU_IN_READY, 1'b1);
        check("release_valid", ALU_OUT_VALID, 1'b0);
        check("release_acc", ALU_ACC, model_acc);
        check("release_dc", ALU_DC, r);
    endtask

    initial begin
        logic [3:0] rctl;
        logic [1:0] ractl;
        rst_n = 1'b0; ALU_IN_VALID = 1'b0; ALU_OUT_READY = 1'b0;
        ALU_DA = '0; ALU_DB = '0; ALU_USE_ACC = 1'b0; ALU_CTL = '0;
        ALU_SHIFT = '0; ACC_CTL = '0;
        repeat (2) @(negedge clk);
        check("rst_dc", ALU_DC, 16'h0);
        check("rst_flags", ALU_FLAGS, 4'h0);
        check("rst_acc", ALU_ACC, 16'h0);
        check("rst_out_valid", ALU_OUT_VALID, 1'b0);
        check("rst_in_ready", ALU_IN_READY, 1'b1);
        rst_n = 1'b1;

        // Directed cases
        do_op(4'd0, 16'h7FFF, 16'h0001, 1'b0, 4'd0, 2'b00, 0);
        check("add_ovf_flags", ALU_FLAGS, 4'b1001);
        do_op(4'd1, 16'h0005, 16'h0005, 1'b0, 4'd0, 2'b00, 0);
        do_op(4'd1, 16'h0000, 16'h0001, 1'b0, 4'd0, 2'b00, 0);
        do_op(4'd6, 16'h8001, 16'h0000, 1'b0, 4'd3, 2'b00, 0);
        check("sra_dc", ALU_DC, 16'hF000);
        do_op(4'd4, 16'h8001, 16'h0000, 1'b0, 4'd1, 2'b00, 0);
        check("sll_dc", ALU_DC, 16'h0002);
        do_op(4'd5, 16'hA5C3, 16'h0000, 1'b0, 4'd0, 2'b00, 0);
        do_op(4'd6, 16'h8000, 16'h0000, 1'b0, 4'd15, 2'b00, 0);
        do_op(4'd8, 16'h0100, 16'h0100, 1'b0, 4'd0, 2'b00, 0);
        check("mul_ovf_flags", ALU_FLAGS, 4'b0111);
        do_op(4'd8, 16'h00FF, 16'h0003, 1'b0, 4'd0, 2'b00, 5);
        check("mul_small_dc", ALU_DC, 16'h02FD);

        // Accumulator sequence
        do_op(4'd0, 16'h1111, 16'h2222, 1'b0, 4'd0, 2'b10, 0);
        do_op(4'd0, 16'hFFFF, 16'h1234, 1'b1, 4'd0, 2'b01, 0);
        check("acc_add", ALU_ACC, 16'h1234);
        do_op(4'd3, 16'h0000, 16'h0000, 1'b0, 4'd0, 2'b11, 0);
        check("acc_compl", ALU_ACC, 16'hEDCB);

        // Reset mid-MUL
        @(negedge clk);
        ALU_CTL = 4'd8; ALU_DA = 16'h1234; ALU_DB = 16'h0F0F; ALU_USE_ACC = 1'b0;
        ACC_CTL = 2'b01; ALU_IN_VALID = 1'b1;
        @(posedge clk); #1;
        ALU_IN_VALID = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_mul_busy", ALU_IN_READY, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", ALU_OUT_VALID, 1'b0);
        check("mid_rst_acc", ALU_ACC, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_acc = 16'h0;
        @(negedge clk);
        check("post_rst_ready", ALU_IN_READY, 1'b1);
        check("post_rst_valid", ALU_OUT_VALID, 1'b0);

        // Randomized ops
        for (int i = 0; i < 150; i++) begin
            rctl  = 4'($urandom_range(0, 15));
            ractl = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            do_op(rctl, 16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom),
                  ractl, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised successor to the 16-bit combinational ALU: a registered, handshaked ALU with an internal accumulator and a status-flag register.
- Adds a multi-cycle unsigned multiply, XOR, a correct arithmetic right shift, and carry-out of shifts.
- Sits between the decode/operand-fetch stage and writeback.
- Uses valid/ready handshakes on input and output, so a stalled consumer backpressures the issuer.

Parameters:
- WIDTH, 16, datapath width. Must be a power of 2, range 8..64.
- SHIFT_W, $clog2(WIDTH), shift-amount width. Derived localparam; do not override.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- ALU_IN_VALID  in  1  operation request valid.
- ALU_IN_READY  out  1  block can accept a request.
- ALU_DA  in  WIDTH  operand A.
- ALU_DB  in  WIDTH  operand B.
- ALU_USE_ACC  in  1  1 = the accumulator replaces ALU_DA as operand A.
- ALU_CTL  in  4  operation code.
- ALU_SHIFT  in  SHIFT_W  shift amount.
- ACC_CTL  in  2  accumulator control.
- ALU_OUT_VALID  out  1  result valid.
- ALU_OUT_READY  in  1  consumer accepts the result.
- ALU_DC  out  WIDTH  registered result.
- ALU_FLAGS  out  4  registered {N,Z,C,V}.
- ALU_ACC  out  WIDTH  current accumulator value.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, ALU_DC=0, ALU_FLAGS=0, ALU_ACC=0, ALU_OUT_VALID=0. Any in-flight MUL is aborted and discarded.
- ALU_IN_READY = (state==IDLE), combinational from state. All inputs are sampled on the accept edge (IN_VALID && IN_READY).
- FSM states: IDLE, MUL, DONE.
  - IDLE → DONE on accept of a non-MUL op.
  - IDLE → MUL on accept of a MUL op.
  - MUL → DONE after WIDTH iterations.
  - DONE → IDLE on ALU_OUT_READY.
- ALU_OUT_VALID = (state==DONE).
- ALU_DC and ALU_FLAGS are written only on the edge that enters DONE. They hold while in DONE and after leaving it.
- Latency and throughput:
  - Single-cycle ops: OUT_VALID asserts the cycle after accept.
  - MUL: OUT_VALID asserts WIDTH+1 cycles after accept.
  - Minimum issue interval is 2 cycles. No new accept is possible while OUT_VALID is high.
- Operand A = ALU_USE_ACC ? ALU_ACC : ALU_DA, captured at accept.
- ALU_CTL encoding:
  - 0000 ADD: C = carry-out; V = signed overflow (operand signs equal, result sign differs).
  - 0001 SUB: computed as A + ~B + 1. C = carry-out, i.e. 1 means no borrow. V = signed overflow.
  - 0010 AND, 0011 OR, 0111 XOR: C=0, V=0.
  - 0100 SLL: C = last bit shifted out (0 if ALU_SHIFT=0). V=0.
  - 0101 SRL: C = last bit shifted out (0 if ALU_SHIFT=0). V=0.
  - 0110 SRA: sign-filled by exactly ALU_SHIFT positions. C = last bit shifted out (0 if ALU_SHIFT=0). V=0.
  - 1000 MUL: unsigned shift-add, one partial product per cycle. ALU_DC = low WIDTH bits of the product. C = V = 1 iff the high WIDTH bits are nonzero.
  - 1001-1111 reserved: result = operand A, C=0, V=0.
- N = result MSB and Z = (result==0) for every op.
- ACC_CTL, sampled at accept:
  - 00: ACC unchanged.
  - 01: ACC <= result on the DONE-entry edge.
  - 10 clear: ALU_CTL is ignored. The op is single-cycle. ACC <= 0 and result = 0 with flags {0,1,0,0}.
  - 11 complement: ALU_CTL is ignored. The op is single-cycle. ACC <= ~ACC_old and result = ~ACC_old. C=0, V=0; N and Z from the result.
- ALU_IN_VALID asserted while IN_READY=0 is ignored. The request is not queued.
- ALU_OUT_READY is ignored outside DONE.

Test Plan:
- WIDTH=16, ADD A=0x7FFF, B=0x0001 → DC=0x8000, FLAGS N=1 Z=0 C=0 V=1, OUT_VALID exactly 1 cycle after accept.
- SUB 0x0005-0x0005 → DC=0x0000, Z=1 C=1 V=0. SUB 0x0000-0x0001 → DC=0xFFFF, N=1 C=0.
- SRA A=0x8001, SHIFT=3 → DC=0xF000, C=0. SLL A=0x8001, SHIFT=1 → DC=0x0002, C=1. SHIFT=0 on any shift op → DC=A, C=0.
- MUL 0x0100*0x0100 → DC=0x0000, Z=1 C=1 V=1, OUT_VALID at cycle 17 after accept. MUL 0x00FF*0x0003 → DC=0x02FD, C=0. IN_READY=0 throughout.
- Backpressure: hold OUT_READY=0 for 5 cycles after a result → DC, FLAGS and OUT_VALID stable, IN_READY=0, new IN_VALID pulses dropped. Release → IDLE next cycle.
- Accumulator sequence, each step accepting a new op: ACC_CTL=10 → ACC=0. ADD with USE_ACC=1, DB=0x1234, ACC_CTL=01 → ACC=0x1234. ACC_CTL=11 → ACC=DC=0xEDCB. Assert rst_n=0 mid-MUL → OUT_VALID=0, ACC=0 immediately, IN_READY=1 after release.
